// File: rtl/bpnn_pkg.sv
// Shared Q8 fixed-point constants, initial weights, FSM states and saturation helper
// for the on-line trained 4-2-2 perceptron core.
package bpnn_pkg;

   localparam int FRAC = 8;
   localparam logic signed [31:0] ONE  = 32'sd256;
   localparam logic signed [31:0] HALF = 32'sd128;

   localparam logic signed [15:0] W_INIT [2][4] = '{
      '{ 16'sd64,  16'sd64, -16'sd64, -16'sd64},
      '{-16'sd64, -16'sd64,  16'sd64,  16'sd64}
   };
   localparam logic signed [15:0] V_INIT [2][2] = '{
      '{ 16'sd128, -16'sd128},
      '{-16'sd128,  16'sd128}
   };

   typedef enum logic [2:0] {
      LATCH, FWD_H, FWD_O, DELTA_O, DELTA_H, UPDATE
   } state_t;

   function automatic logic signed [15:0] sat16(input logic signed [31:0] val);
      if (val > 32'sd32767)
         return 16'sh7fff;
      else if (val < -32'sd32768)
         return 16'sh8000;
      else
         return val[15:0];
   endfunction

endpackage

// File: rtl/bpnn_neuron_act.sv
// Hard-sigmoid activation of a pre-activation value plus slope scaling of an error term;
// the slope leaks (>>>5) outside the linear region so saturated units keep learning.
module bpnn_neuron_act
   import bpnn_pkg::*;
(
   input  logic signed [31:0] s,
   input  logic signed [31:0] val,
   output logic signed [31:0] act,
   output logic signed [31:0] scaled
);

   logic signed [31:0] q;
   logic               lin;

   always_comb begin
      q   = (s >>> 2) + HALF;
      lin = (q > 0) && (q < ONE);
      if (q < 0)
         act = '0;
      else if (q > ONE)
         act = ONE;
      else
         act = q;
      scaled = lin ? (val >>> 2) : (val >>> 5);
   end

endmodule

// File: rtl/backprop_nn_core.sv
// On-line trained 4-2-2 multilayer perceptron: one forward pass and one backprop weight
// update every six cycles, looping forever on whatever sample the host presents.
module backprop_nn_core
   import bpnn_pkg::*;
#(
   parameter int LR_SHIFT = 1,
   parameter int WW       = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic signed [8:0] x0,
   input  logic signed [8:0] x1,
   input  logic signed [8:0] x2,
   input  logic signed [8:0] x3,
   input  logic signed [8:0] desired_y0,
   input  logic signed [8:0] desired_y1,
   output logic              y0,
   output logic              y1
);

   state_t state, state_nxt;
   logic   en_latch, en_fwdh, en_fwdo, en_dlto, en_dlth, en_upd;

   logic signed [WW-1:0] w [2][4];
   logic signed [WW-1:0] b [2];
   logic signed [WW-1:0] v [2][2];
   logic signed [WW-1:0] c [2];

   logic signed [8:0]  x_in [4];
   logic signed [8:0]  x_r  [4];
   logic signed [31:0] t_r  [2];
   logic signed [31:0] s_r  [2];
   logic signed [31:0] h_r  [2];
   logic signed [31:0] p_r  [2];
   logic signed [31:0] o_r  [2];
   logic signed [31:0] d_r  [2];
   logic signed [31:0] e_r  [2];

   logic signed [31:0] s_sum [2], s_comb [2];
   logic signed [31:0] p_sum [2], p_comb [2];
   logic signed [31:0] bp_sum [2], bp [2];
   logic signed [31:0] h_act [2], e_next [2];
   logic signed [31:0] o_act [2], d_next [2];

   assign x_in[0] = x0;
   assign x_in[1] = x1;
   assign x_in[2] = x2;
   assign x_in[3] = x3;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         state <= LATCH;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = LATCH;
      case (state)
         LATCH:   state_nxt = FWD_H;
         FWD_H:   state_nxt = FWD_O;
         FWD_O:   state_nxt = DELTA_O;
         DELTA_O: state_nxt = DELTA_H;
         DELTA_H: state_nxt = UPDATE;
         UPDATE:  state_nxt = LATCH;
         default: state_nxt = LATCH;
      endcase
   end

   always_comb begin
      en_latch = 1'b0;
      en_fwdh  = 1'b0;
      en_fwdo  = 1'b0;
      en_dlto  = 1'b0;
      en_dlth  = 1'b0;
      en_upd   = 1'b0;
      case (state)
         LATCH:   en_latch = 1'b1;
         FWD_H:   en_fwdh  = 1'b1;
         FWD_O:   en_fwdo  = 1'b1;
         DELTA_O: en_dlto  = 1'b1;
         DELTA_H: en_dlth  = 1'b1;
         UPDATE:  en_upd   = 1'b1;
         default: en_latch = 1'b0;
      endcase
   end

   // Full-width sums are accumulated before the Q8 rescale shift.
   always_comb begin
      for (int j = 0; j < 2; j++) begin
         s_sum[j] = '0;
         for (int i = 0; i < 4; i++)
            s_sum[j] = s_sum[j] + 32'(w[j][i]) * 32'(x_r[i]);
         s_comb[j] = (s_sum[j] >>> FRAC) + 32'(b[j]);
      end
      for (int k = 0; k < 2; k++) begin
         p_sum[k] = '0;
         for (int j = 0; j < 2; j++)
            p_sum[k] = p_sum[k] + 32'(v[k][j]) * h_r[j];
         p_comb[k] = (p_sum[k] >>> FRAC) + 32'(c[k]);
      end
      for (int j = 0; j < 2; j++) begin
         bp_sum[j] = '0;
         for (int k = 0; k < 2; k++)
            bp_sum[j] = bp_sum[j] + 32'(v[k][j]) * d_r[k];
         bp[j] = bp_sum[j] >>> FRAC;
      end
   end

   for (genvar j = 0; j < 2; j++) begin : g_hid
      bpnn_neuron_act u_act (
         .s      (en_fwdh ? s_comb[j] : s_r[j]),
         .val    (bp[j]),
         .act    (h_act[j]),
         .scaled (e_next[j])
      );
   end

   for (genvar k = 0; k < 2; k++) begin : g_out
      bpnn_neuron_act u_act (
         .s      (en_fwdo ? p_comb[k] : p_r[k]),
         .val    (t_r[k] - o_r[k]),
         .act    (o_act[k]),
         .scaled (d_next[k])
      );
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         y0 <= 1'b0;
         y1 <= 1'b0;
         for (int j = 0; j < 2; j++) begin
            b[j]   <= '0;
            s_r[j] <= '0;
            h_r[j] <= '0;
            e_r[j] <= '0;
            for (int i = 0; i < 4; i++)
               w[j][i] <= WW'(W_INIT[j][i]);
         end
         for (int k = 0; k < 2; k++) begin
            c[k]   <= '0;
            t_r[k] <= '0;
            p_r[k] <= '0;
            o_r[k] <= '0;
            d_r[k] <= '0;
            for (int j = 0; j < 2; j++)
               v[k][j] <= WW'(V_INIT[k][j]);
         end
         for (int i = 0; i < 4; i++)
            x_r[i] <= '0;
      end else begin
         if (en_latch) begin
            for (int i = 0; i < 4; i++)
               x_r[i] <= x_in[i];
            t_r[0] <= (desired_y0 != 0) ? ONE : 32'sd0;
            t_r[1] <= (desired_y1 != 0) ? ONE : 32'sd0;
         end
         if (en_fwdh) begin
            for (int j = 0; j < 2; j++) begin
               s_r[j] <= s_comb[j];
               h_r[j] <= h_act[j];
            end
         end
         if (en_fwdo) begin
            for (int k = 0; k < 2; k++) begin
               p_r[k] <= p_comb[k];
               o_r[k] <= o_act[k];
            end
            y0 <= (o_act[0] >= HALF);
            y1 <= (o_act[1] >= HALF);
         end
         if (en_dlto) begin
            for (int k = 0; k < 2; k++)
               d_r[k] <= d_next[k];
         end
         if (en_dlth) begin
            for (int j = 0; j < 2; j++)
               e_r[j] <= e_next[j];
         end
         if (en_upd) begin
            for (int k = 0; k < 2; k++) begin
               c[k] <= WW'(sat16(32'(c[k]) + (d_r[k] >>> LR_SHIFT)));
               for (int j = 0; j < 2; j++)
                  v[k][j] <= WW'(sat16(32'(v[k][j]) +
                                       ((d_r[k] * h_r[j]) >>> (FRAC + LR_SHIFT))));
            end
            for (int j = 0; j < 2; j++) begin
               b[j] <= WW'(sat16(32'(b[j]) + (e_r[j] >>> LR_SHIFT)));
               for (int i = 0; i < 4; i++)
                  w[j][i] <= WW'(sat16(32'(w[j][i]) +
                                       ((e_r[j] * 32'(x_r[i])) >>> (FRAC + LR_SHIFT))));
            end
         end
      end
   end

endmodule

// File: tb/tb_backprop_nn_core.sv
// Self-checking bench: an integer-arithmetic model of one training iteration predicts
// every y decision and every weight/bias after each update.
module tb_backprop_nn_core;

   logic              CLK = 1'b0;
   logic              RST;
   logic signed [8:0] x0, x1, x2, x3, desired_y0, desired_y1;
   logic              y0, y1;

   int n_checks = 0;
   int n_fail   = 0;

   int cx [4];
   int ct [2];
   int mw [2][4];
   int mb [2];
   int mv [2][2];
   int mc [2];
   int exp_y0, exp_y1;

   always #5 CLK = ~CLK;

   backprop_nn_core #(.LR_SHIFT(1), .WW(16)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .x0         (x0),
      .x1         (x1),
      .x2         (x2),
      .x3         (x3),
      .desired_y0 (desired_y0),
      .desired_y1 (desired_y1),
      .y0         (y0),
      .y1         (y1)
   );

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int act_m(int s);
      int q = (s >>> 2) + 128;
      if (q < 0) return 0;
      if (q > 256) return 256;
      return q;
   endfunction

   function automatic int slope_m(int s, int val);
      int q = (s >>> 2) + 128;
      return (q > 0 && q < 256) ? (val >>> 2) : (val >>> 5);
   endfunction

   function automatic int sat_m(int val);
      if (val > 32767) return 32767;
      if (val < -32768) return -32768;
      return val;
   endfunction

   task automatic model_reset();
      mw[0] = '{64, 64, -64, -64};
      mw[1] = '{-64, -64, 64, 64};
      mv[0] = '{128, -128};
      mv[1] = '{-128, 128};
      mb = '{0, 0};
      mc = '{0, 0};
   endtask

   // One full forward/backward/update pass on the current sample cx/ct.
   task automatic model_iter();
      int s [2], h [2], p [2], o [2], d [2], e [2], tg [2];
      int acc;
      for (int k = 0; k < 2; k++) tg[k] = (ct[k] != 0) ? 256 : 0;
      for (int j = 0; j < 2; j++) begin
         acc = 0;
         for (int i = 0; i < 4; i++) acc += mw[j][i] * cx[i];
         s[j] = (acc >>> 8) + mb[j];
         h[j] = act_m(s[j]);
      end
      for (int k = 0; k < 2; k++) begin
         acc = mv[k][0] * h[0] + mv[k][1] * h[1];
         p[k] = (acc >>> 8) + mc[k];
         o[k] = act_m(p[k]);
         d[k] = slope_m(p[k], tg[k] - o[k]);
      end
      for (int j = 0; j < 2; j++) begin
         acc = mv[0][j] * d[0] + mv[1][j] * d[1];
         e[j] = slope_m(s[j], acc >>> 8);
      end
      exp_y0 = (o[0] >= 128) ? 1 : 0;
      exp_y1 = (o[1] >= 128) ? 1 : 0;
      for (int k = 0; k < 2; k++) begin
         mc[k] = sat_m(mc[k] + (d[k] >>> 1));
         for (int j = 0; j < 2; j++) mv[k][j] = sat_m(mv[k][j] + ((d[k] * h[j]) >>> 9));
      end
      for (int j = 0; j < 2; j++) begin
         mb[j] = sat_m(mb[j] + (e[j] >>> 1));
         for (int i = 0; i < 4; i++) mw[j][i] = sat_m(mw[j][i] + ((e[j] * cx[i]) >>> 9));
      end
   endtask

   task automatic check_weights(input string tag);
      for (int j = 0; j < 2; j++) begin
         check($sformatf("%s_b%0d", tag, j), dut.b[j], mb[j]);
         for (int i = 0; i < 4; i++)
            check($sformatf("%s_w%0d%0d", tag, j, i), dut.w[j][i], mw[j][i]);
      end
      for (int k = 0; k < 2; k++) begin
         check($sformatf("%s_c%0d", tag, k), dut.c[k], mc[k]);
         for (int j = 0; j < 2; j++)
            check($sformatf("%s_v%0d%0d", tag, k, j), dut.v[k][j], mv[k][j]);
      end
   endtask

   task automatic drive_inputs();
      x0 = 9'(cx[0]);
      x1 = 9'(cx[1]);
      x2 = 9'(cx[2]);
      x3 = 9'(cx[3]);
      desired_y0 = 9'(ct[0]);
      desired_y1 = 9'(ct[1]);
   endtask

   task automatic scramble_inputs();
      x0 = 9'($urandom);
      x1 = 9'($urandom);
      x2 = 9'($urandom);
      x3 = 9'($urandom);
      desired_y0 = 9'($urandom);
      desired_y1 = 9'($urandom);
   endtask

   // Called just before the LATCH edge; returns 1 time unit after the UPDATE edge.
   task automatic run_iter(input string tag);
      drive_inputs();
      model_iter();
      @(posedge CLK);
      #1 scramble_inputs();
      repeat (2) @(posedge CLK);
      #1;
      check({tag, "_y0"}, y0, exp_y0);
      check({tag, "_y1"}, y1, exp_y1);
      repeat (3) @(posedge CLK);
      #1 check_weights(tag);
   endtask

   task automatic set_sample(input int a, input int b2, input int c2, input int d2,
                             input int t0, input int t1);
      cx = '{a, b2, c2, d2};
      ct = '{t0, t1};
   endtask

   initial begin
      RST = 1'b1;
      set_sample(0, 0, 0, 0, 0, 0);
      drive_inputs();
      model_reset();
      repeat (3) @(posedge CLK);
      #1;
      check("rst_y0", y0, 0);
      check("rst_y1", y1, 0);
      check_weights("rst");
      @(negedge CLK) RST = 1'b0;

      set_sample(159, 205, 81, 76, 0, 1);
      run_iter("a0");
      check("a0_first_y0", y0, 1);
      check("a0_first_y1", y1, 0);
      for (int n = 1; n < 4; n++) run_iter("a");
      check("a_end_y0", y0, 0);
      check("a_end_y1", y1, 1);

      set_sample(168, 218, 37, 36, 0, 1);
      for (int n = 0; n < 4; n++) run_iter("b");
      set_sample(111, 216, 3, 89, 0, 1);
      for (int n = 0; n < 4; n++) run_iter("c");
      set_sample(238, 216, 9, 8, 0, 1);
      for (int n = 0; n < 4; n++) run_iter("d");
      set_sample(78, 101, 214, 226, 0, 0);
      for (int n = 0; n < 4; n++) run_iter("e");

      for (int n = 0; n < 8; n++) begin
         set_sample(int'($urandom_range(511)) - 256, int'($urandom_range(511)) - 256,
                    int'($urandom_range(511)) - 256, int'($urandom_range(511)) - 256,
                    int'($urandom_range(1)) * int'($urandom_range(255, 1)),
                    -int'($urandom_range(1)));
         run_iter("rnd");
      end

      // Asynchronous reset while the UPDATE state is active.
      set_sample(159, 205, 81, 76, 0, 1);
      drive_inputs();
      repeat (5) @(posedge CLK);
      #2 RST = 1'b1;
      #1;
      check("midrst_y0", y0, 0);
      check("midrst_y1", y1, 0);
      model_reset();
      check_weights("midrst");
      @(negedge CLK) RST = 1'b0;
      run_iter("post");
      check("post_first_y0", y0, 1);
      check("post_first_y1", y1, 0);

      cx = '{255, 255, 255, 255};
      for (int n = 0; n < 167; n++) begin
         ct = (n % 2 == 0) ? '{1, 1} : '{0, 0};
         run_iter("sat");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
